// File: rtl/ysyx_210184_wb_arbiter.sv
// ysyx_210184_wb_arbiter: merges pipeline writeback and buffered long-unit results onto
// the single register-file write port, tracking pending long results in a busy scoreboard.
module ysyx_210184_wb_arbiter #(
    parameter int REG_W = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic [REG_W-1:0] wb_data,
    input  logic             lu_valid,
    output logic             lu_ready,
    input  logic [4:0]       lu_rd,
    input  logic [REG_W-1:0] lu_data,
    input  logic             lu_issue,
    input  logic [4:0]       lu_issue_rd,
    output logic             w_ena,
    output logic [4:0]       w_addr,
    output logic [REG_W-1:0] w_data,
    output logic [31:0]      busy_vec,
    output logic             err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [4:0]       rd_q  [DEPTH];
    logic [REG_W-1:0] dat_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             w_ena_q, w_ena_d, err_q, err_d;
    logic [4:0]       w_addr_q, w_addr_d, head_rd, sel_rd;
    logic [REG_W-1:0] w_data_q, w_data_d, sel_data;
    logic [31:0]      busy_q, busy_d, clr, set;
    logic             full, empty, push, pop;

    assign full     = cnt_q == FULL_CNT;
    assign empty    = cnt_q == '0;
    assign lu_ready = !full;
    assign w_ena    = w_ena_q;
    assign w_addr   = w_addr_q;
    assign w_data   = w_data_q;
    assign busy_vec = busy_q;
    assign err      = err_q;

    always_comb begin
        push     = lu_valid && !full;
        pop      = !wb_valid && !empty;
        head_rd  = rd_q[rp_q];
        sel_rd   = wb_valid ? wb_rd : head_rd;
        sel_data = wb_valid ? wb_data : dat_q[rp_q];
        w_ena_d  = (wb_valid || pop) && sel_rd != 5'd0;
        w_addr_d = w_ena_d ? sel_rd : w_addr_q;
        w_data_d = w_ena_d ? sel_data : w_data_q;
        // clear applied before set so a fresh issue of the same rd stays pending
        clr      = (pop && head_rd != 5'd0) ? (32'd1 << head_rd) : 32'd0;
        set      = (lu_issue && lu_issue_rd != 5'd0) ? (32'd1 << lu_issue_rd) : 32'd0;
        busy_d   = ((busy_q & ~clr) | set) & ~32'd1;
        err_d    = err_q | (wb_valid && wb_rd != 5'd0 && busy_q[wb_rd])
                         | (pop && head_rd != 5'd0 && !busy_q[head_rd]);
        wp_d     = push ? wp_q + AW'(1) : wp_q;
        rp_d     = pop ? rp_q + AW'(1) : rp_q;
        cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wp_q]  <= lu_rd;
            dat_q[wp_q] <= lu_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            w_ena_q  <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
            busy_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            w_ena_q  <= w_ena_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: doc/ysyx_210184_wb_arbiter.md
# ysyx_210184_wb_arbiter

Writeback arbiter that owns the single register-file write port (w_ena/w_addr/w_data). It merges two result sources into that port: the in-order pipeline writeback, which cannot be stalled, and a long-latency unit (divider/multi-cycle load), which uses a valid/ready handshake. Long-latency results are buffered in a small FIFO. A per-register busy scoreboard tells decode which architectural registers still await a long-latency result.

## Interface
- REG_W, 64, data width of a register.
- DEPTH, 2, long-result FIFO entries; must be a power of two, at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- wb_valid  in  1  pipeline result valid this cycle; always accepted.
- wb_rd  in  5  pipeline destination register.
- wb_data  in  REG_W  pipeline result.
- lu_valid  in  1  long-unit result valid.
- lu_ready  out  1  arbiter can accept a long-unit result.
- lu_rd  in  5  long-unit destination register.
- lu_data  in  REG_W  long-unit result.
- lu_issue  in  1  decode issued a long-latency op this cycle.
- lu_issue_rd  in  5  destination register of the issued op.
- w_ena  out  1  register-file write enable (registered).
- w_addr  out  5  register-file write address (registered).
- w_data  out  REG_W  register-file write data (registered).
- busy_vec  out  32  bit i = 1: x[i] awaits a long-unit write.
- err  out  1  sticky protocol-violation flag.

## Operation
- Long-unit handshake: a transfer occurs when lu_valid && lu_ready. The entry {lu_rd, lu_data} is pushed into the FIFO at that edge.
- lu_ready = !full. There is no pass-through when full, even if a pop happens in the same cycle.
- Arbitration is evaluated each cycle:
  - wb_valid=1: the pipeline wins. Output registers load {wb_rd, wb_data}, and the FIFO holds.
  - wb_valid=0 and FIFO non-empty: pop the head into the output registers.
  - Otherwise: w_ena loads 0.
- Every load into the output registers sets w_ena = 1 only if the selected rd != 0.
  - An x0 entry is still consumed or popped, but does not write.
  - When w_ena = 0, w_addr and w_data hold their previous values.
- FIFO: read and write pointers of log2(DEPTH) bits wrap modulo DEPTH, plus an occupancy count of 0..DEPTH.
  - full = (count == DEPTH); empty = (count == 0).
  - A simultaneous push and pop leaves count unchanged.
- Scoreboard:
  - lu_issue && lu_issue_rd != 0 sets busy_vec[lu_issue_rd] at the edge.
  - A FIFO pop with rd != 0 clears busy_vec[rd] at the same edge that asserts w_ena for it.
  - Set and clear of the same rd in one cycle: set wins, because a newer issue is outstanding.
  - busy_vec[0] is always 0.
- err: set and held until reset when either of these occurs:
  - wb_valid && wb_rd != 0 && busy_vec[wb_rd] (write-after-write against a pending long result);
  - a pop with rd != 0 finds busy_vec[rd] == 0.

## Timing
- Reset (rst=0, asynchronous) drives all outputs to 0: w_ena=0, w_addr=0, w_data=0, busy_vec=0, err=0.
  - FIFO pointers and count go to 0, so lu_ready=1 from the first cycle after release.
  - Entries in flight when reset asserts are discarded.
- Pipeline latency: wb_valid in cycle c gives w_ena in cycle c+1.
- Long-unit latency: a handshake in cycle c pushes at edge c. The pop is at the earliest in cycle c+1, giving w_ena in cycle c+2. Each cycle of wb_valid=1 delays the pop by one cycle.
- Throughput: one register-file write per cycle. The FIFO drains one entry per cycle in which wb_valid=0.
- busy_vec and err are registered; each changes on the edge after its cause.
- The register file forwards w_data combinationally while w_ena=1. Decode may therefore read a register in the same cycle its busy bit drops.

## Test plan
- Reset, then wb_valid=1, wb_rd=5, wb_data=0x1234 for one cycle: next cycle w_ena=1, w_addr=5, w_data=0x1234; the cycle after, w_ena=0.
- lu_issue with rd=7, then an lu handshake with rd=7, data=0xAA, and wb_valid=0: busy_vec[7]=1 until the write; w_ena=1 with addr 7 and data 0xAA two cycles after the handshake; busy_vec[7]=0 in that same cycle; err stays 0.
- wb_valid held at 1 for 4 cycles while the long unit offers 3 results: the third result sees lu_ready=0 (FIFO full at DEPTH=2). After wb_valid drops, the two buffered results drain in order on consecutive cycles, then the third is accepted.
- lu handshake with rd=0 and data=0xFF: a FIFO pop occurs but w_ena stays 0; busy_vec stays 0.
- With busy_vec[9]=1, wb_valid=1 and wb_rd=9: err=1 next cycle and stays set until rst=0.
- Assert rst=0 mid-cycle with the FIFO holding 2 entries: all outputs go to 0 immediately; after release, lu_ready=1 and no stale write appears.
